// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_pkg: opcode constants, fetch state encoding, instruction width |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] BNE   = 6'h05;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// +--------------------------------------------------------------------+
// | instr_fetch_unit_if: instruction-memory req/ack bus                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    import cpu_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/next_pc_sel.sv
// +--------------------------------------------------------------------+
// | next_pc_sel: next PC selection (jump > taken branch > pc+4)        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module next_pc_sel #(
    parameter int ADDR_W = 32
) (
    input  wire [ADDR_W-1:0] pc_plus4,
    input  wire [25:0]       instr_idx,   // instr[25:0]; low 16 bits are the branch offset
    input  wire              branch,
    input  wire              zero_inv,
    input  wire              alu_zero,
    input  wire              jump,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign
);

    logic              w_taken;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_j_target;

    assign w_taken     = branch & (alu_zero ^ zero_inv);
    assign w_br_target = pc_plus4 + {{(ADDR_W-18){instr_idx[15]}}, instr_idx[15:0], 2'b00};
    assign w_j_target  = {pc_plus4[ADDR_W-1:28], instr_idx, 2'b00};

    always_comb begin
        if (jump) begin
            next_pc = w_j_target;
        end else if (w_taken) begin
            next_pc = w_br_target;
        end else begin
            next_pc = pc_plus4;
        end
    end

    assign misalign = (next_pc[1:0] != 2'b00);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// +--------------------------------------------------------------------+
// | instr_fetch_unit: PC owner, req/ack fetch, instr hold, next-PC     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                ACK_TMO  = 15
) (
    input  wire                clk,
    input  wire                rst,
    instr_fetch_unit_if.master imem,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4,
    input  wire                retire,
    input  wire                branch,
    input  wire                zero_inv,
    input  wire                alu_zero,
    input  wire                jump,
    output logic               fetch_err
);

    // Counter only has to reach ACK_TMO-1; the cycle it would hit ACK_TMO raises the error.
    localparam int                 C_TMO_W    = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'((ACK_TMO > 0) ? ACK_TMO - 1 : 0);
    localparam bit                 C_TMO_EN   = (ACK_TMO > 0);

    fetch_state_t        r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_valid;
    logic                r_req;
    logic                r_err;
    logic [C_TMO_W-1:0]  r_tmo_cnt;

    logic [ADDR_W-1:0]   w_pc_plus4;
    logic [ADDR_W-1:0]   w_next_pc;
    logic                w_misalign;

    assign w_pc_plus4 = r_pc + ADDR_W'(4);

    next_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_sel (
        .pc_plus4  (w_pc_plus4),
        .instr_idx (r_instr[25:0]),
        .branch    (branch),
        .zero_inv  (zero_inv),
        .alu_zero  (alu_zero),
        .jump      (jump),
        .next_pc   (w_next_pc),
        .misalign  (w_misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_valid   <= 1'b0;
            r_req     <= 1'b0;
            r_err     <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state   <= FETCH;
                    r_req     <= 1'b1;
                    r_tmo_cnt <= '0;
                end
                FETCH: begin
                    if (imem.imem_ack) begin
                        r_instr <= imem.imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= HOLD;
                    end else if (C_TMO_EN && (r_tmo_cnt == C_TMO_LAST)) begin
                        r_err   <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= ERR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + C_TMO_W'(1);
                    end
                end
                HOLD: begin
                    if (retire) begin
                        r_valid <= 1'b0;
                        // A misaligned target leaves pc on the offending instruction.
                        if (w_misalign) begin
                            r_err   <= 1'b1;
                            r_state <= ERR;
                        end else begin
                            r_pc      <= w_next_pc;
                            r_req     <= 1'b1;
                            r_tmo_cnt <= '0;
                            r_state   <= FETCH;
                        end
                    end
                end
                ERR: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_pc;
    assign instr          = r_instr;
    assign instr_valid    = r_valid;
    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign fetch_err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// +--------------------------------------------------------------------+
// | tb_instr_fetch_unit: vectors, random retire stream, corner cases   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v;
    logic        retire, branch, zero_inv, alu_zero, jump;
    logic        mem_en, force_ack;
    logic [31:0] mem_word;
    int          sel;

    instr_fetch_unit_if #(.ADDR_W(32)) bus0 ();
    instr_fetch_unit_if #(.ADDR_W(32)) bus1 ();
    instr_fetch_unit_if #(.ADDR_W(32)) bus2 ();

    // force_ack lets the bench inject an ack with no request outstanding.
    assign bus0.imem_ack   = mem_en & (bus0.imem_req | force_ack);
    assign bus1.imem_ack   = mem_en & (bus1.imem_req | force_ack);
    assign bus2.imem_ack   = mem_en & (bus2.imem_req | force_ack);
    assign bus0.imem_rdata = mem_word;
    assign bus1.imem_rdata = mem_word;
    assign bus2.imem_rdata = mem_word;

    logic [31:0] instr0, instr1, instr2, pc0, pc1, pc2, pcp0, pcp1, pcp2;
    logic        v0, v1, v2, e0, e1, e2;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .ACK_TMO(15)) u_main (
        .clk(clk), .rst(rst_v[0]), .imem(bus0), .instr(instr0), .instr_valid(v0),
        .pc(pc0), .pc_plus4(pcp0), .retire(retire), .branch(branch), .zero_inv(zero_inv),
        .alu_zero(alu_zero), .jump(jump), .fetch_err(e0));

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h4000_0000), .ACK_TMO(15)) u_alt (
        .clk(clk), .rst(rst_v[1]), .imem(bus1), .instr(instr1), .instr_valid(v1),
        .pc(pc1), .pc_plus4(pcp1), .retire(retire), .branch(branch), .zero_inv(zero_inv),
        .alu_zero(alu_zero), .jump(jump), .fetch_err(e1));

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0002), .ACK_TMO(0)) u_mis (
        .clk(clk), .rst(rst_v[2]), .imem(bus2), .instr(instr2), .instr_valid(v2),
        .pc(pc2), .pc_plus4(pcp2), .retire(retire), .branch(branch), .zero_inv(zero_inv),
        .alu_zero(alu_zero), .jump(jump), .fetch_err(e2));

    logic [31:0] obs_instr, obs_pc, obs_pcp, obs_addr;
    logic        obs_req, obs_valid, obs_err;

    always_comb begin
        obs_instr = instr0; obs_pc = pc0; obs_pcp = pcp0; obs_addr = bus0.imem_addr;
        obs_req = bus0.imem_req; obs_valid = v0; obs_err = e0;
        case (sel)
            1: begin
                obs_instr = instr1; obs_pc = pc1; obs_pcp = pcp1; obs_addr = bus1.imem_addr;
                obs_req = bus1.imem_req; obs_valid = v1; obs_err = e1;
            end
            2: begin
                obs_instr = instr2; obs_pc = pc2; obs_pcp = pcp2; obs_addr = bus2.imem_addr;
                obs_req = bus2.imem_req; obs_valid = v2; obs_err = e2;
            end
            default: ;
        endcase
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rpc(input int s);
        case (s)
            1:       return 32'h4000_0000;
            2:       return 32'h0000_0002;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Reference next-PC from the architectural rules.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                               input bit br, input bit zi, input bit z, input bit j);
        logic [31:0] p4;
        int          off;
        p4  = cur + 32'd4;
        off = $signed(w[15:0]) * 4;
        if (j)              return {p4[31:28], w[25:0], 2'b00};
        if (br && (z != zi)) return p4 + 32'(off);
        return p4;
    endfunction

    task automatic do_reset(input int s);
        rst_v = 3'b111;
        retire = 0; branch = 0; zero_inv = 0; alu_zero = 0; jump = 0; force_ack = 0;
        sel = s;
        repeat (2) @(negedge clk);
        check("rst_req",   obs_req,   0);
        check("rst_valid", obs_valid, 0);
        check("rst_err",   obs_err,   0);
        check("rst_pc",    obs_pc,    rpc(s));
        check("rst_instr", obs_instr, 0);
        rst_v[s] = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                         input int delay, input bit noise);
        int n;
        bit seen;
        n = 0; seen = 0;
        mem_word = word;
        mem_en   = (delay == 0);
        while (!obs_valid && n < 40) begin
            if (obs_req && !seen) begin
                seen = 1;
                check("fetch_addr", obs_addr, exp_addr);
            end
            if (noise) begin
                retire = 1'($urandom); branch = 1'($urandom); zero_inv = 1'($urandom);
                alu_zero = 1'($urandom); jump = 1'($urandom);
            end
            @(negedge clk);
            n++;
            if (n >= delay) mem_en = 1'b1;
        end
        retire = 0; branch = 0; zero_inv = 0; alu_zero = 0; jump = 0;
        check("fetch_valid", obs_valid, 1);
        check("fetch_instr", obs_instr, word);
        check("fetch_pc",    obs_pc,    exp_addr);
        check("fetch_pcp4",  obs_pcp,   exp_addr + 32'd4);
        check("fetch_reqlo", obs_req,   0);
    endtask

    task automatic retire_instr(input bit br, input bit zi, input bit z, input bit j,
                                input logic [31:0] exp_next);
        retire = 1; branch = br; zero_inv = zi; alu_zero = z; jump = j;
        @(negedge clk);
        retire = 0;
        branch = 1'($urandom); zero_inv = 1'($urandom); alu_zero = 1'($urandom); jump = 1'($urandom);
        check("ret_valid", obs_valid, 0);
        check("ret_req",   obs_req,   1);
        check("next_addr", obs_addr,  exp_next);
        check("ret_err",   obs_err,   0);
    endtask

    typedef struct {
        logic [31:0] word;
        logic        br, zi, z, j;
        int          delay;
        logic [31:0] nxt;
    } vec_t;

    vec_t tv[18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cur, w, exp;
        bit          br, zi, z, j;
        int          reqs, n;

        tv[0]  = '{32'h2002_0005, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0004};
        tv[1]  = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0008};
        tv[2]  = '{32'h8C01_0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 32'h0000_000C};
        tv[3]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0008};
        tv[4]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0004};
        tv[5]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 2, 32'h0000_0008};
        tv[6]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0000_000C};
        tv[7]  = '{32'h0800_0002, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0000_0008};
        tv[8]  = '{32'h1400_FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'h0000_0004};
        tv[9]  = '{32'h1400_FFFE, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h0000_0008};
        tv[10] = '{32'h1400_FFFE, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h0000_000C};
        tv[11] = '{32'h0800_0010, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h0000_0040};
        tv[12] = '{32'h1000_C000, 1'b1, 1'b0, 1'b1, 1'b0, 4, 32'hFFFF_0044};
        tv[13] = '{32'h0BFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'hFFFF_FFFC};
        tv[14] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0000};
        tv[15] = '{32'h1000_0003, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0010};
        tv[16] = '{32'h1000_0003, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h0000_0014};
        tv[17] = '{32'h0800_0010, 1'b0, 1'b0, 1'b0, 1'b0, 5, 32'h0000_0018};

        // Reset and zero-wait first fetch.
        mem_en = 1; mem_word = 32'h2002_0005;
        do_reset(0);
        @(negedge clk);
        check("c1_req",   obs_req,   1);
        check("c1_addr",  obs_addr,  0);
        check("c1_valid", obs_valid, 0);
        @(negedge clk);
        check("c2_valid", obs_valid, 1);
        check("c2_pc",    obs_pc,    0);
        check("c2_pcp4",  obs_pcp,   4);

        cur = 32'h0;
        for (int i = 0; i < 18; i++) begin
            fetch(cur, tv[i].word, tv[i].delay, 1'b0);
            retire_instr(tv[i].br, tv[i].zi, tv[i].z, tv[i].j, tv[i].nxt);
            cur = tv[i].nxt;
        end

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       w = {6'h02, 26'($urandom)};
                1:       w = {($urandom_range(0, 1) == 1) ? 6'h05 : 6'h04, 26'($urandom)};
                default: w = $urandom;
            endcase
            br = 1'($urandom); zi = 1'($urandom); z = 1'($urandom);
            j  = ($urandom_range(0, 3) == 0);
            exp = model_next(cur, w, br, zi, z, j);
            fetch(cur, w, $urandom_range(0, 6), 1'b1);
            retire_instr(br, zi, z, j, exp);
            cur = exp;
        end
        fetch(cur, 32'hAC41_0008, 0, 1'b0);

        // Memory never acknowledges.
        mem_en = 0;
        do_reset(0);
        reqs = 0; n = 0;
        while (!obs_err && n < 40) begin
            if (obs_req) reqs++;
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", 32'(reqs), 15);
        check("tmo_err",    obs_err,   1);
        check("tmo_req",    obs_req,   0);
        check("tmo_valid",  obs_valid, 0);
        mem_en = 1; force_ack = 1;
        repeat (5) @(negedge clk);
        force_ack = 0;
        check("tmo_sticky", obs_err,   1);
        check("tmo_req2",   obs_req,   0);
        check("tmo_valid2", obs_valid, 0);

        // Reset during FETCH with an ack arriving right after.
        mem_en = 0;
        do_reset(0);
        repeat (3) @(negedge clk);
        check("mid_req_before", obs_req, 1);
        mem_word = 32'h8C22_0004;
        #2;
        rst_v[0] = 1'b1; force_ack = 1; mem_en = 1;
        #1;
        check("mid_req_async", obs_req, 0);
        @(negedge clk);
        check("mid_valid_rst", obs_valid, 0);
        rst_v[0] = 1'b0;
        @(negedge clk);
        check("mid_valid_late", obs_valid, 0);
        check("mid_req_refetch", obs_req, 1);
        check("mid_addr", obs_addr, 0);
        force_ack = 0;
        fetch(32'h0, 32'h8C22_0004, 0, 1'b0);

        // Jump beats branch in the upper address region.
        mem_en = 1;
        do_reset(1);
        fetch(32'h4000_0000, 32'h0800_0010, 0, 1'b0);
        retire_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h4000_0040);
        fetch(32'h4000_0040, 32'h0000_0000, 2, 1'b0);

        // Misaligned reset PC with timeout disabled.
        mem_en = 0;
        do_reset(2);
        repeat (20) @(negedge clk);
        check("notmo_req", obs_req, 1);
        check("notmo_err", obs_err, 0);
        fetch(32'h0000_0002, 32'h0000_0020, 0, 1'b0);
        retire = 1;
        @(negedge clk);
        retire = 0;
        check("mis_err",   obs_err,   1);
        check("mis_req",   obs_req,   0);
        check("mis_valid", obs_valid, 0);
        check("mis_pc",    obs_pc,    32'h0000_0002);
        repeat (5) @(negedge clk);
        check("mis_sticky", obs_err, 1);
        check("mis_req2",   obs_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
